// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: channel-side and sink-side handshake bundle of the stream mux
interface stream_mux_rr_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*WIDTH-1:0] in_data_i;
   logic [NUM_IN-1:0]       in_valid_i;
   logic [NUM_IN-1:0]       in_ready_o;
   logic                    mode_i;
   logic [SEL_W-1:0]        sel_i;
   logic [WIDTH-1:0]        out_data_o;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [SEL_W-1:0]        out_sel_o;
   // the mux itself
   modport slave (
      input  in_data_i, in_valid_i, mode_i, sel_i, out_ready_i,
      output in_ready_o, out_data_o, out_valid_o, out_sel_o
   );
   // sources, sink and select control around the mux
   modport master (
      output in_data_i, in_valid_i, mode_i, sel_i, out_ready_i,
      input  in_ready_o, out_data_o, out_valid_o, out_sel_o
   );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_IN-way stream mux (fixed select or round-robin) with a registered output stage; STREAM_MUX_STATS_EN adds a handshake counter
module stream_mux_rr #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input logic clk_i,
   input logic rst_ni,
`ifdef STREAM_MUX_STATS_EN
   output logic [31:0] xfer_cnt_o,
`endif
   stream_mux_rr_if.slave bus
);
   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  gnt_idx;
   logic [SEL_W-1:0]  cand;
   logic [SEL_W-1:0]  ptr_nxt;
   logic [SEL_W:0]    rr_sum;
   logic              gnt_vld;
   logic              accept;
   logic              xfer;
   logic [NUM_IN-1:0] grant;
   logic [WIDTH-1:0]  gnt_data;
   logic [WIDTH-1:0]  out_data;
   logic [SEL_W-1:0]  out_sel;
   logic              out_valid;

   // pick the granted channel: first valid from the pointer (wrapping) in rr mode, sel_i in fixed mode
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_sum  = '0;
      cand    = '0;
      if (bus.mode_i) begin
         for (int i = 0; i < NUM_IN; i++) begin
            rr_sum = {1'b0, ptr} + (SEL_W+1)'(i);
            if (rr_sum >= (SEL_W+1)'(NUM_IN)) rr_sum = rr_sum - (SEL_W+1)'(NUM_IN);
            cand = rr_sum[SEL_W-1:0];
            if (!gnt_vld && bus.in_valid_i[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end else if ({1'b0, bus.sel_i} < (SEL_W+1)'(NUM_IN)) begin
         gnt_vld = bus.in_valid_i[bus.sel_i];
         gnt_idx = bus.sel_i;
      end
   end

   assign accept         = ~out_valid | bus.out_ready_i;
   assign grant          = {{(NUM_IN-1){1'b0}}, gnt_vld} << gnt_idx;
   assign bus.in_ready_o = grant & {NUM_IN{accept & rst_ni}};
   assign xfer           = gnt_vld & accept;
   assign gnt_data       = bus.in_data_i[gnt_idx*WIDTH +: WIDTH];
   assign ptr_nxt        = (gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;
   assign bus.out_data_o  = out_data;
   assign bus.out_sel_o   = out_sel;
   assign bus.out_valid_o = out_valid;

   // output register: load on transfer, clear valid on a drain without reload, hold while stalled
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_sel   <= gnt_idx;
      end else if (bus.out_ready_i) begin
         out_valid <= 1'b0;
      end
   end

   // round-robin pointer advances past the winner, only on rr-mode transfers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr <= '0;
      else if (xfer && bus.mode_i) ptr <= ptr_nxt;
   end

`ifdef STREAM_MUX_STATS_EN
   // saturating count of completed output handshakes
   always_ff @(posedge clk_i) begin
      if (!rst_ni) xfer_cnt_o <= '0;
      else if (out_valid && bus.out_ready_i && xfer_cnt_o != 32'hFFFF_FFFF) xfer_cnt_o <= xfer_cnt_o + 32'd1;
   end
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of reset, fixed select, round-robin, backpressure and mid-stream reset
module tb_stream_mux_rr;
   localparam int WIDTH  = 32;
   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
`ifdef STREAM_MUX_STATS_EN
   logic [31:0] xfer_cnt;
`endif

   stream_mux_rr_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

   stream_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
`ifdef STREAM_MUX_STATS_EN
      .xfer_cnt_o(xfer_cnt),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
      bus.in_data_i[k*WIDTH +: WIDTH] = v;
   endtask

   task automatic set_all_plus10();
      for (int k = 0; k < NUM_IN; k++) set_ch(k, WIDTH'(k + 10));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.in_valid_i = '0;
      bus.out_ready_i = 1'b1;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mode_i = 1'b1;
      bus.sel_i = '0;
      bus.in_valid_i = 4'b1111;
      bus.out_ready_i = 1'b1;
      set_all_plus10();
      step();
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", bus.out_valid_o); end
      checks++; if (bus.out_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data_o); end
      checks++; if (bus.out_sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel got %h want 0", bus.out_sel_o); end
      checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", bus.in_ready_o); end
      rst_n = 1'b1;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0001) begin errors++; $display("FAIL release_in_ready got %b want 0001", bus.in_ready_o); end
      step();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL release_valid got %h want 1", bus.out_valid_o); end
      checks++; if (bus.out_sel_o !== 2'd0) begin errors++; $display("FAIL release_sel got %h want 0", bus.out_sel_o); end
      checks++; if (bus.out_data_o !== 32'd10) begin errors++; $display("FAIL release_data got %h want a", bus.out_data_o); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_sel;
      logic [31:0] exp_data;
      apply_reset();
      bus.mode_i = 1'b1;
      bus.in_valid_i = 4'b1111;
      set_all_plus10();
      for (int i = 0; i < 5; i++) begin
         exp_sel  = 2'(i % 4);
         exp_data = 32'(i % 4 + 10);
         step();
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %h want 1", i, bus.out_valid_o); end
         checks++; if (bus.out_sel_o !== exp_sel) begin errors++; $display("FAIL rr_sel[%0d] got %h want %h", i, bus.out_sel_o, exp_sel); end
         checks++; if (bus.out_data_o !== exp_data) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", i, bus.out_data_o, exp_data); end
      end
   endtask

   task automatic test_fixed_select();
      apply_reset();
      bus.mode_i = 1'b0;
      bus.sel_i = 2'd2;
      bus.in_valid_i = 4'b0101;
      set_ch(2, 32'h5);
      set_ch(0, 32'h3);
      #1;
      checks++; if (bus.in_ready_o !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready got %b want 0100", bus.in_ready_o); end
      step();
      checks++; if (bus.out_data_o !== 32'h5) begin errors++; $display("FAIL fixed_data got %h want 5", bus.out_data_o); end
      checks++; if (bus.out_sel_o !== 2'd2) begin errors++; $display("FAIL fixed_sel got %h want 2", bus.out_sel_o); end
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL fixed_valid got %h want 1", bus.out_valid_o); end
      bus.sel_i = 2'd1;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL fixed_invalid_ready got %b want 0000", bus.in_ready_o); end
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL fixed_drain_valid got %h want 0", bus.out_valid_o); end
      bus.mode_i = 1'b1;
      bus.in_valid_i = 4'b1111;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0001) begin errors++; $display("FAIL fixed_ptr_kept got %b want 0001", bus.in_ready_o); end
      step();
      checks++; if (bus.out_data_o !== 32'h3) begin errors++; $display("FAIL fixed_to_rr_data got %h want 3", bus.out_data_o); end
   endtask

   task automatic test_rr_skip_wrap();
      apply_reset();
      bus.mode_i = 1'b1;
      set_all_plus10();
      bus.in_valid_i = 4'b0100;
      step();
      checks++; if (bus.out_sel_o !== 2'd2) begin errors++; $display("FAIL wrap_setup_sel got %h want 2", bus.out_sel_o); end
      bus.in_valid_i = 4'b0011;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b want 0001", bus.in_ready_o); end
      step();
      checks++; if (bus.out_data_o !== 32'd10) begin errors++; $display("FAIL wrap_data0 got %h want a", bus.out_data_o); end
      #1;
      checks++; if (bus.in_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_ready1 got %b want 0010", bus.in_ready_o); end
      step();
      checks++; if (bus.out_sel_o !== 2'd1) begin errors++; $display("FAIL wrap_sel1 got %h want 1", bus.out_sel_o); end
      checks++; if (bus.out_data_o !== 32'd11) begin errors++; $display("FAIL wrap_data1 got %h want b", bus.out_data_o); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.mode_i = 1'b1;
      set_ch(1, 32'h7);
      set_ch(2, 32'h22);
      bus.in_valid_i = 4'b0010;
      step();
      checks++; if (bus.out_data_o !== 32'h7) begin errors++; $display("FAIL bp_load_data got %h want 7", bus.out_data_o); end
      bus.out_ready_i = 1'b0;
      bus.in_valid_i = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, bus.in_ready_o); end
         step();
         checks++; if (bus.out_data_o !== 32'h7) begin errors++; $display("FAIL bp_hold_data[%0d] got %h want 7", i, bus.out_data_o); end
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %h want 1", i, bus.out_valid_o); end
         checks++; if (bus.out_sel_o !== 2'd1) begin errors++; $display("FAIL bp_hold_sel[%0d] got %h want 1", i, bus.out_sel_o); end
      end
      bus.out_ready_i = 1'b1;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", bus.in_ready_o); end
      step();
      checks++; if (bus.out_data_o !== 32'h22) begin errors++; $display("FAIL bp_reload_data got %h want 22", bus.out_data_o); end
      checks++; if (bus.out_sel_o !== 2'd2) begin errors++; $display("FAIL bp_reload_sel got %h want 2", bus.out_sel_o); end
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %h want 1", bus.out_valid_o); end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      bus.mode_i = 1'b1;
      bus.in_valid_i = 4'b1111;
      set_all_plus10();
      repeat (6) step();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL mid_valid got %h want 1", bus.out_valid_o); end
      checks++; if (bus.out_data_o !== 32'd11) begin errors++; $display("FAIL mid_data got %h want b", bus.out_data_o); end
`ifdef STREAM_MUX_STATS_EN
      checks++; if (xfer_cnt !== 32'd5) begin errors++; $display("FAIL mid_cnt got %0d want 5", xfer_cnt); end
`endif
      rst_n = 1'b0;
      #1;
      checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", bus.in_ready_o); end
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %h want 0", bus.out_valid_o); end
      checks++; if (bus.out_data_o !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0", bus.out_data_o); end
`ifdef STREAM_MUX_STATS_EN
      checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", xfer_cnt); end
`endif
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_data_i = '0;
      bus.in_valid_i = '0;
      bus.mode_i = 1'b0;
      bus.sel_i = '0;
      bus.out_ready_i = 1'b1;
      test_reset();
      test_round_robin();
      test_fixed_select();
      test_rr_skip_wrap();
      test_backpressure();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
